regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with per-register busy scoreboard. It is the next generation of the datapath register file and adds configurable width and depth, two independent read ports, and an optional same-cycle write-to-read bypass. It also adds asynchronous clear and a pending-write scoreboard so the controller FSM can stall on operands not yet written back. It sits between the instruction decoder/controller and the ALU operand latches.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers (2..32; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; do not override)
- BYPASS, 1, 1 = write data forwarded to a matching read port in the same cycle; 0 = reads return stored value only
- clk  in  1  single clock, rising-edge
- reset_n  in  1  asynchronous active-low reset
- data_in  in  WIDTH  write data
- writenum  in  AW  write address
- write  in  1  write enable
- readnum_a  in  AW  read address, port A
- readnum_b  in  AW  read address, port B
- data_out_a  out  WIDTH  read data, port A
- data_out_b  out  WIDTH  read data, port B
- ready_a  out  1  port A register has no pending write
- ready_b  out  1  port B register has no pending write
- issue  in  1  mark register issuenum busy (write pending)
- issuenum  in  AW  register to mark busy
- busy  out  DEPTH  scoreboard vector, bit i = register i pending

## Operation
- Storage: DEPTH registers of WIDTH bits. Register i loads data_in on a rising clk when write=1 and writenum=i; otherwise it holds.
- Reads are combinational. Port A and port B are independent and may address the same register.
- BYPASS=1: when write=1 and writenum equals a read address, that port outputs data_in in the same cycle. BYPASS=0: that port outputs the stored value, and the new value appears after the edge.
- Out-of-range address (value >= DEPTH): write is ignored, read returns 0, ready returns 1, issue is ignored.
- Scoreboard: a rising edge with issue=1 sets busy[issuenum]. A rising edge with write=1 clears busy[writenum].
- Same edge, same register, issue and write both asserted: busy ends set, because the new pending write supersedes the old one. Data is still written.
- Same edge, different registers: both actions take effect.
- ready_x = ~busy[readnum_x]. With BYPASS=1, a write to that register in the current cycle also forces ready_x=1, unless issue targets the same register in that cycle.
- Reset (reset_n=0, asynchronous): all registers are cleared to 0 and busy is cleared to 0. While reset is held, data_out_a and data_out_b are 0 (the bypass is disabled during reset) and ready_a and ready_b are 1. Writes and issues in progress when reset asserts are lost.

## Timing
- Write latency: 1 edge to storage, 0 cycles to the read port with BYPASS=1, 1 cycle with BYPASS=0.
- Scoreboard latency: busy changes 1 edge after issue/write; ready follows combinationally.
- Reset assertion takes effect immediately without waiting for clk. On deassertion, the first rising edge after reset_n rises is the first one that can write.
- No combinational path from issue/issuenum to data_out.

## Structure
- Shared package: the WIDTH/DEPTH defaults, AW derivation, and the out-of-range read value (0).
- One sub-module, regfile_cell: a WIDTH-bit register with asynchronous active-low clear and load enable. It is instantiated DEPTH times, plus one DEPTH-bit instance for busy, which uses per-bit set/clear logic outside the cell.
- Write decode and read muxing are generate loops over DEPTH, with no fixed one-hot case lists.

## Test plan
- Reset, then read all addresses on both ports → data_out_a and data_out_b are 0, busy=0, ready_a=ready_b=1. Then write R3=16'h00AB → next cycle readnum_a=3 gives 16'h00AB.
- BYPASS=1: write=1, writenum=5, data_in=16'h1234, readnum_a=readnum_b=5 in the same cycle → both ports show 16'h1234 before the edge. Repeat with BYPASS=0 → old value before the edge, 16'h1234 after it.
- Issue R2 → busy=8'b0000_0100 and ready_a=0 for readnum_a=2. Write R2=16'h0F0F → busy=0 and ready_a=1 on the next cycle.
- Same edge: issue R6 and write R6=16'h5555 → R6=16'h5555 and busy[6]=1. Same edge with issue R1 and write R4 → busy[1]=1 and busy[4]=0.
- DEPTH=5: write to address 6 → no register changes. Read address 7 → data 0, ready 1. Issue 7 → busy unchanged.
- Assert reset_n low mid-cycle while write=1 to R0 and issue R1 are active → immediate clear with no edge needed. After release, R0=0 and busy=0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
//   Shared constants for the scoreboarded register file: default geometry,
//   address-width derivation and the value returned for unmapped reads.
package regfile_sb_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_DEPTH_DEF = 8;

  // Unmapped read addresses return every bit at this level.
  localparam logic RD_OOR_BIT = 1'b0;

  // Address width for a given depth; depth is always >= 2, but stay
  // well-defined for depth 1 so elaboration never sees a zero-width bus.
  function automatic int rf_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// regfile_cell
//   W-bit storage element with asynchronous active-low clear and load enable.
//   Ports:
//     clk    in   rising-edge clock
//     clr_n  in   asynchronous clear, active low
//     en     in   load enable
//     d      in   W  load data
//     q      out  W  stored value
module regfile_cell #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
//   DEPTH x WIDTH register file, two combinational read ports, optional
//   same-cycle write-to-read bypass, and a per-register pending-write
//   scoreboard used by the controller to stall on unwritten operands.
//   Ports:
//     clk                 in   rising-edge clock
//     reset_n             in   asynchronous reset, active low
//     data_in/writenum    in   write data / address, committed when write=1
//     readnum_a/_b        in   read addresses
//     data_out_a/_b       out  read data (0 for unmapped addresses)
//     ready_a/_b          out  addressed register has no pending write
//     issue/issuenum      in   mark issuenum busy at the next edge
//     busy                out  DEPTH-bit scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int AW     = rf_aw(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             ready_a,
  output logic             ready_b,
  input  logic             issue,
  input  logic [AW-1:0]    issuenum,
  output logic [DEPTH-1:0] busy
);

  localparam logic BYP_EN = (BYPASS != 0);

  // One-hot decodes. Addresses >= DEPTH match no index, so out-of-range
  // writes/issues fall away and out-of-range reads select nothing.
  logic [DEPTH-1:0]            we, iss, sel_a, sel_b;
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy_d, busy_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign we[i]    = write && (writenum  == AW'(i));
    assign iss[i]   = issue && (issuenum  == AW'(i));
    assign sel_a[i] = (readnum_a == AW'(i));
    assign sel_b[i] = (readnum_b == AW'(i));

    regfile_cell #(.W(WIDTH)) u_cell (
      .clk   (clk),
      .clr_n (reset_n),
      .en    (we[i]),
      .d     (data_in),
      .q     (regs[i])
    );
  end

  // Scoreboard: a write retires the pending mark, an issue on the same edge
  // re-arms it because that newer write is still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = iss[i] | (busy_q[i] & ~we[i]);
    end
  end

  regfile_cell #(.W(DEPTH)) u_busy (
    .clk   (clk),
    .clr_n (reset_n),
    .en    (1'b1),
    .d     (busy_d),
    .q     (busy_q)
  );

  assign busy = busy_q;

  // Stored-value read muxes; the default covers unmapped addresses.
  logic [WIDTH-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = {WIDTH{RD_OOR_BIT}};
    rd_b = {WIDTH{RD_OOR_BIT}};
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_a[i]) rd_a = regs[i];
      if (sel_b[i]) rd_b = regs[i];
    end
  end

  // Bypass hit: a valid write targets the port's register this cycle.
  // Disabled in reset so the ports read 0 even with write held high.
  logic byp_a, byp_b, iss_a, iss_b, bsy_a, bsy_b;

  always_comb begin
    byp_a = BYP_EN && reset_n && (|(we & sel_a));
    byp_b = BYP_EN && reset_n && (|(we & sel_b));
    iss_a = |(iss & sel_a);
    iss_b = |(iss & sel_b);
    bsy_a = |(busy_q & sel_a);
    bsy_b = |(busy_q & sel_b);
  end

  always_comb begin
    data_out_a = rd_a;
    data_out_b = rd_b;
    if (!reset_n) begin
      data_out_a = '0;
      data_out_b = '0;
    end else begin
      if (byp_a) data_out_a = data_in;
      if (byp_b) data_out_b = data_in;
    end
  end

  // A bypassed write satisfies the operand now, unless a fresh issue to the
  // same register is opening another pending write this cycle.
  always_comb begin
    ready_a = ~bsy_a;
    ready_b = ~bsy_b;
    if (!reset_n) begin
      ready_a = 1'b1;
      ready_b = 1'b1;
    end else begin
      if (byp_a && !iss_a) ready_a = 1'b1;
      if (byp_b && !iss_b) ready_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [2:0]  writenum, readnum_a, readnum_b, issuenum;
  logic        write, issue;

  // u8: DEPTH 8 bypass; u8n: DEPTH 8 no bypass; u5: DEPTH 5 bypass
  logic [15:0] da8, db8, da8n, db8n, da5, db5;
  logic        ra8, rb8, ra8n, rb8n, ra5, rb5;
  logic [7:0]  busy8, busy8n;
  logic [4:0]  busy5;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u8 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(da8), .data_out_b(db8), .ready_a(ra8), .ready_b(rb8),
    .issue(issue), .issuenum(issuenum), .busy(busy8));

  regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u8n (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(da8n), .data_out_b(db8n), .ready_a(ra8n), .ready_b(rb8n),
    .issue(issue), .issuenum(issuenum), .busy(busy8n));

  regfile_sb #(.WIDTH(16), .DEPTH(5), .BYPASS(1)) u5 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(da5), .data_out_b(db5), .ready_a(ra5), .ready_b(rb5),
    .issue(issue), .issuenum(issuenum), .busy(busy5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp5 [5];
    reset_n = 1'b0; write = 1'b0; issue = 1'b0; data_in = '0;
    writenum = '0; readnum_a = '0; readnum_b = '0; issuenum = '0;
    #2;
    // Reset state across every address on both ports
    for (int i = 0; i < 8; i++) begin
      readnum_a = 3'(i); readnum_b = 3'(7 - i);
      #1;
      chk($sformatf("rst_da8_%0d", i), da8, 0);
      chk($sformatf("rst_db8_%0d", i), db8, 0);
      chk($sformatf("rst_rdy8_%0d", i), {ra8, rb8}, 2'b11);
      chk($sformatf("rst_da5_%0d", i), da5, 0);
      chk($sformatf("rst_rdy5_%0d", i), {ra5, rb5}, 2'b11);
    end
    chk("rst_busy8", busy8, 0);
    chk("rst_busy5", busy5, 0);
    @(negedge clk); reset_n = 1'b1;

    // Write R3 = 00AB, readable next cycle on every instance
    tick();
    write = 1'b1; writenum = 3; data_in = 16'h00AB; readnum_a = 0;
    tick();
    write = 1'b0; readnum_a = 3;
    #1;
    chk("r3_da8", da8, 16'h00AB);
    chk("r3_da8n", da8n, 16'h00AB);
    chk("r3_da5", da5, 16'h00AB);

    // Bypass R5 = 1234 on both ports
    write = 1'b1; writenum = 5; data_in = 16'h1234; readnum_a = 5; readnum_b = 5;
    #1;
    chk("byp_da8", da8, 16'h1234);
    chk("byp_db8", db8, 16'h1234);
    chk("nobyp_da8n_pre", da8n, 16'h0000);
    chk("oor_byp_da5", da5, 16'h0000);
    tick();
    write = 1'b0;
    #1;
    chk("nobyp_da8n_post", da8n, 16'h1234);
    chk("nobyp_db8n_post", db8n, 16'h1234);
    chk("oor_wr_da5", da5, 16'h0000);
    chk("oor_rdy5", ra5, 1'b1);

    // Issue R2 then retire it with a write
    issue = 1'b1; issuenum = 2; readnum_a = 2;
    #1;
    chk("iss_busy_pre", busy8, 8'h00);
    tick();
    issue = 1'b0;
    #1;
    chk("iss_busy8", busy8, 8'b0000_0100);
    chk("iss_rdy8", ra8, 1'b0);
    chk("iss_rdy8n", ra8n, 1'b0);
    chk("iss_busy5", busy5, 5'b00100);
    write = 1'b1; writenum = 2; data_in = 16'h0F0F;
    #1;
    chk("wr2_byp_rdy8", ra8, 1'b1);
    chk("wr2_nobyp_rdy8n", ra8n, 1'b0);
    chk("wr2_byp_da8", da8, 16'h0F0F);
    tick();
    write = 1'b0;
    #1;
    chk("wr2_busy8", busy8, 8'h00);
    chk("wr2_rdy8", ra8, 1'b1);
    chk("wr2_rdy8n", ra8n, 1'b1);
    chk("wr2_da8n", da8n, 16'h0F0F);

    // Same edge, same register: issue wins the scoreboard, data still lands
    issue = 1'b1; issuenum = 6; write = 1'b1; writenum = 6; data_in = 16'h5555;
    readnum_a = 6;
    #1;
    chk("same_pre_da8", da8, 16'h5555);
    chk("same_pre_rdy8", ra8, 1'b1);
    tick();
    issue = 1'b0; write = 1'b0;
    #1;
    chk("same_da8", da8, 16'h5555);
    chk("same_busy8", busy8, 8'h40);
    chk("same_rdy8", ra8, 1'b0);
    chk("same_busy8n", busy8n, 8'h40);
    chk("same_oor_busy5", busy5, 5'b00000);

    // Same edge, different registers
    issue = 1'b1; issuenum = 1; write = 1'b1; writenum = 4; data_in = 16'hAAAA;
    tick();
    issue = 1'b0; write = 1'b0; readnum_a = 4;
    #1;
    chk("diff_busy8", busy8, 8'h42);
    chk("diff_busy5", busy5, 5'b00010);
    chk("diff_da8", da8, 16'hAAAA);
    chk("diff_da5", da5, 16'hAAAA);

    // DEPTH 5: write to address 6 changes nothing there (u8 takes it)
    write = 1'b1; writenum = 6; data_in = 16'hFFFF;
    tick();
    write = 1'b0;
    exp5 = '{16'h0000, 16'h0000, 16'h0F0F, 16'h00AB, 16'hAAAA};
    for (int i = 0; i < 5; i++) begin
      readnum_a = 3'(i);
      #1;
      chk($sformatf("oor_keep_r%0d", i), da5, exp5[i]);
    end
    chk("wr6_busy8", busy8, 8'h02);
    readnum_a = 6;
    #1;
    chk("wr6_da8", da8, 16'hFFFF);
    readnum_a = 7;
    #1;
    chk("oor_rd7_da5", da5, 16'h0000);
    chk("oor_rd7_rdy5", ra5, 1'b1);
    issue = 1'b1; issuenum = 7;
    tick();
    issue = 1'b0;
    #1;
    chk("oor_iss7_busy5", busy5, 5'b00010);
    chk("iss7_busy8", busy8, 8'h82);
    chk("iss7_rdy8", ra8, 1'b0);
    chk("oor_iss7_rdy5", ra5, 1'b1);

    // Asynchronous reset mid-cycle with a write and an issue in flight
    write = 1'b1; writenum = 0; data_in = 16'hBEEF; issue = 1'b1; issuenum = 1;
    readnum_a = 0; readnum_b = 7;
    #1;
    chk("pre_rst_da8", da8, 16'hBEEF);
    chk("pre_rst_rdyb8", rb8, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_busy8", busy8, 8'h00);
    chk("arst_busy5", busy5, 5'b00000);
    chk("arst_da8", da8, 16'h0000);
    chk("arst_rdyb8", rb8, 1'b1);
    readnum_a = 3;
    #1;
    chk("arst_r3_da8", da8, 16'h0000);
    @(negedge clk);
    write = 1'b0; issue = 1'b0;
    tick();
    @(negedge clk); reset_n = 1'b1;
    tick();
    readnum_a = 0; readnum_b = 6;
    #1;
    chk("post_rst_r0", da8, 16'h0000);
    chk("post_rst_r6", db8, 16'h0000);
    chk("post_rst_busy8", busy8, 8'h00);
    chk("post_rst_busy8n", busy8n, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
